atm_bank_responder: RTL and testbench
=====================================

Name: atm_bank_responder

Overview:
- Account-side responder for the ATM controller. It answers PIN-verify, withdraw, current-balance and mini-statement requests.
- Returns pin_check, transaction_success and balance_enquiry_success after a fixed processing latency.
- Holds the account balance, PIN retry/lockout state and a circular history of the last HIST_DEPTH withdrawals.
- Sits between the ATM FSM and the cash/receipt peripherals.

Parameters:
- BAL_W, 16: width of balance, amount and history entries.
- INIT_BALANCE, 1000: balance loaded on reset.
- PIN_CODE, 16'h1234: stored account PIN.
- MAX_TRIES, 3: consecutive wrong PINs before lockout (>=1).
- PROC_LAT, 4: processing cycles between request acceptance and response (>=1).
- HIST_DEPTH, 4: withdrawal history entries (power of 2, >=2).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request strobe; sampled only in IDLE.
- req_op  in  2  00 verify PIN, 01 withdraw, 10 current balance, 11 mini statement.
- pin_in  in  16  PIN presented with op 00.
- amount_in  in  BAL_W  withdraw amount with op 01.
- session_end  in  1  clears the session (pin_ok) on the next edge.
- busy  out  1  high while a request is in progress (WAIT/RESP/STREAM).
- resp_valid  out  1  one-cycle response pulse.
- pin_check  out  1  PIN result; registered, held until the next response.
- transaction_success  out  1  withdraw result; held until the next response.
- balance_enquiry_success  out  1  enquiry result; held until the next response.
- locked  out  1  sticky lockout flag.
- balance  out  BAL_W  current balance, registered.
- hist_valid  out  1  history entry valid (mini-statement stream).
- hist_data  out  BAL_W  history entry; newest first.

Behaviour:
- Reset values:
  - State IDLE.
  - busy, resp_valid, pin_check, transaction_success, balance_enquiry_success, locked, hist_valid all 0.
  - hist_data 0; balance = INIT_BALANCE.
  - Retry count 0, pin_ok 0, history count 0, write pointer 0.
- Reset mid-operation aborts immediately:
  - No response is issued.
  - The balance is restored to INIT_BALANCE.
  - History is cleared.
- States:
  - IDLE -> WAIT on req_valid. The edge latches req_op, pin_in and amount_in and loads the latency counter with PROC_LAT-1.
  - WAIT decrements the counter; at 0 -> RESP.
  - RESP: evaluates the op, updates results, drives resp_valid=1 for this single cycle.
  - From RESP: op 11 with success -> STREAM; otherwise -> IDLE.
  - STREAM: emits one history entry per cycle with hist_valid=1, newest to oldest, count = min(logged withdrawals, HIST_DEPTH). Returns to IDLE after the last entry; a zero count returns to IDLE immediately with no hist_valid.
- Latency:
  - Request sampled at edge E0.
  - resp_valid is high in the cycle after edge E0+PROC_LAT.
  - busy is high from E0 until return to IDLE.
- req_valid outside IDLE is ignored; there is no queueing and no error.
- Op 00, verify PIN:
  - When locked: pin_check=0, regardless of the PIN.
  - Else on match: pin_check=1, pin_ok=1, retry count=0.
  - Else on mismatch: pin_check=0, retry count+1. On reaching MAX_TRIES, locked=1 in the same RESP cycle; locked stays set until reset.
- Op 01, withdraw:
  - Success iff pin_ok, amount!=0 and amount<=balance (unsigned compare).
  - On success: balance -= amount, visible the cycle after RESP.
  - On success the amount is written to history at the write pointer. The pointer wraps modulo HIST_DEPTH; when full, the oldest entry is overwritten and the count saturates at HIST_DEPTH.
  - On failure: balance and history unchanged. No underflow is possible.
- Ops 10/11:
  - balance_enquiry_success = pin_ok.
  - The balance is unchanged.
- Result flags not relevant to the op are cleared to 0 at each RESP.
- session_end:
  - Clears pin_ok at the next edge, in any state.
  - The requirement is that the op executes with pin_ok as it stands at RESP. Consequently, a session_end anywhere before RESP makes the pending request fail its pin_ok check.
- Locked does not clear pin_ok for a session that is already open.

Test Plan:
1. Reset -> balance=1000, all flags 0. Verify 1234 at E0 -> resp_valid exactly at cycle E0+5, pin_check=1, busy high for 5 cycles.
2. Three verifies with 0000 -> pin_check=0 each; locked=1 in the third RESP. A fourth verify with 1234 -> pin_check=0, locked stays 1.
3. After a good PIN, withdraw 300 -> transaction_success=1, balance=700. Withdraw 800 -> success=0, balance=700. Withdraw 0 -> success=0.
4. Five withdrawals of 10,20,30,40,50 then a mini statement -> balance_enquiry_success=1, then 4 consecutive hist_valid cycles with 50,40,30,20.
5. req_valid pulsed during WAIT -> ignored, exactly one resp_valid. session_end before RESP on a withdraw -> transaction_success=0, balance unchanged.
6. Reset asserted during WAIT of a withdraw 100 -> no resp_valid, balance=1000, history empty. A subsequent mini statement without a PIN -> success=0, no stream.

Source files
------------

// File: rtl/atm_bank_responder.sv
// Account-side responder for the ATM controller: PIN check with lockout, withdraw,
// balance enquiry and a newest-first mini-statement stream, all after a fixed latency.
module atm_bank_responder #(
  parameter int          BAL_W        = 16,
  parameter int          INIT_BALANCE = 1000,
  parameter logic [15:0] PIN_CODE     = 16'h1234,
  parameter int          MAX_TRIES    = 3,
  parameter int          PROC_LAT     = 4,
  parameter int          HIST_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [15:0]      pin_in,
  input  logic [BAL_W-1:0] amount_in,
  input  logic             session_end,
  output logic             busy,
  output logic             resp_valid,
  output logic             pin_check,
  output logic             transaction_success,
  output logic             balance_enquiry_success,
  output logic             locked,
  output logic [BAL_W-1:0] balance,
  output logic             hist_valid,
  output logic [BAL_W-1:0] hist_data
);

  localparam int CNT_W  = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int PTR_W  = $clog2(HIST_DEPTH);
  localparam int HCNT_W = $clog2(HIST_DEPTH + 1);

  localparam logic [1:0] OP_PIN  = 2'b00;
  localparam logic [1:0] OP_WD   = 2'b01;
  localparam logic [1:0] OP_STMT = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, STREAM} state_t;

  state_t             state, state_next;
  logic [1:0]         op_q;
  logic [15:0]        pin_q;
  logic [BAL_W-1:0]   amount_q;
  logic [CNT_W-1:0]   lat_cnt;
  logic [TRY_W-1:0]   retry_cnt;
  logic [TRY_W-1:0]   retry_inc;
  logic               pin_ok;
  logic               pin_ok_eff;
  logic               pin_match;
  logic               wd_ok;
  logic               enter_resp;
  logic               stream_last;
  logic [BAL_W-1:0]   hist_mem [HIST_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [HCNT_W-1:0]  hist_count;
  logic [HCNT_W-1:0]  stream_idx;

  // Results are evaluated on the edge into RESP so they are visible alongside resp_valid;
  // a session_end arriving on that same edge must still void the pending request.
  assign enter_resp  = (state == WAIT) && (lat_cnt == '0);
  assign pin_ok_eff  = pin_ok && !session_end;
  assign pin_match   = (pin_q == PIN_CODE);
  assign wd_ok       = pin_ok_eff && (amount_q != '0) && (amount_q <= balance);
  assign retry_inc   = (retry_cnt == TRY_W'(MAX_TRIES)) ? retry_cnt : retry_cnt + TRY_W'(1);
  assign stream_last = ((stream_idx + HCNT_W'(1)) >= hist_count);
  assign rd_ptr      = wr_ptr - PTR_W'(1) - stream_idx[PTR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    resp_valid = 1'b0;
    hist_valid = 1'b0;
    hist_data  = '0;
    case (state)
      IDLE: begin
        if (req_valid) state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (lat_cnt == '0) state_next = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (op_q == OP_STMT && balance_enquiry_success) state_next = STREAM;
        else                                            state_next = IDLE;
      end
      STREAM: begin
        busy = 1'b1;
        if (stream_idx < hist_count) begin
          hist_valid = 1'b1;
          hist_data  = hist_mem[rd_ptr];
        end
        if (stream_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q                    <= '0;
      pin_q                   <= '0;
      amount_q                <= '0;
      lat_cnt                 <= '0;
      retry_cnt               <= '0;
      pin_ok                  <= 1'b0;
      pin_check               <= 1'b0;
      transaction_success     <= 1'b0;
      balance_enquiry_success <= 1'b0;
      locked                  <= 1'b0;
      balance                 <= BAL_W'(INIT_BALANCE);
      wr_ptr                  <= '0;
      hist_count              <= '0;
      stream_idx              <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_q     <= req_op;
        pin_q    <= pin_in;
        amount_q <= amount_in;
        lat_cnt  <= CNT_W'(PROC_LAT - 1);
      end else if (state == WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
      end

      if (enter_resp) begin
        pin_check               <= 1'b0;
        transaction_success     <= 1'b0;
        balance_enquiry_success <= 1'b0;
        case (op_q)
          OP_PIN: begin
            if (!locked) begin
              if (pin_match) begin
                pin_check <= 1'b1;
                retry_cnt <= '0;
              end else begin
                retry_cnt <= retry_inc;
                if (retry_inc >= TRY_W'(MAX_TRIES)) locked <= 1'b1;
              end
            end
          end
          OP_WD:   transaction_success     <= wd_ok;
          default: balance_enquiry_success <= pin_ok_eff;
        endcase
      end

      if (session_end) pin_ok <= 1'b0;
      else if (enter_resp && op_q == OP_PIN && !locked && pin_match) pin_ok <= 1'b1;

      // Withdrawals commit as RESP retires, so the new balance appears the cycle after.
      if (state == RESP && op_q == OP_WD && transaction_success) begin
        balance          <= balance - amount_q;
        hist_mem[wr_ptr] <= amount_q;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        if (hist_count != HCNT_W'(HIST_DEPTH)) hist_count <= hist_count + HCNT_W'(1);
      end

      if (state == RESP)        stream_idx <= '0;
      else if (state == STREAM) stream_idx <= stream_idx + HCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_atm_bank_responder.sv
// Directed self-checking bench for atm_bank_responder with default parameters.
module tb_atm_bank_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] pin_in = 16'h0;
  logic [15:0] amount_in = 16'h0;
  logic        session_end = 1'b0;
  logic        busy, resp_valid, pin_check, transaction_success;
  logic        balance_enquiry_success, locked, hist_valid;
  logic [15:0] balance, hist_data;

  int total = 0;
  int bad = 0;
  int lat, bcnt, hfirst, hlast, rcnt;
  logic [15:0] hq[$];

  atm_bank_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .pin_in(pin_in), .amount_in(amount_in), .session_end(session_end),
    .busy(busy), .resp_valid(resp_valid), .pin_check(pin_check),
    .transaction_success(transaction_success),
    .balance_enquiry_success(balance_enquiry_success), .locked(locked),
    .balance(balance), .hist_valid(hist_valid), .hist_data(hist_data)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; session_end = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 20 && busy; g++) begin
      @(posedge clk); #1;
    end
  endtask

  // Returns edges from acceptance to resp_valid (-1 on timeout), left sitting in the RESP cycle.
  task automatic do_req(input logic [1:0] op, input logic [15:0] pin, input logic [15:0] amt,
                        output int l, output int b);
    wait_idle();
    req_valid = 1'b1; req_op = op; pin_in = pin; amount_in = amt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    l = -1; b = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) b++;
      if (resp_valid) begin
        l = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic collect_stream();
    hq.delete(); hfirst = -1; hlast = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (hist_valid) begin
        hq.push_back(hist_data);
        if (hfirst < 0) hfirst = i;
        hlast = i;
      end
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (balance !== 16'd1000) begin bad++; $display("[TB] FAIL reset_balance got=%0d want=1000", balance); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp got=%0b want=0", resp_valid); end
    total++; if ({pin_check, transaction_success, balance_enquiry_success, locked} !== 4'b0)
      begin bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {pin_check, transaction_success, balance_enquiry_success, locked}); end
    total++; if (hist_valid !== 1'b0 || hist_data !== 16'd0)
      begin bad++; $display("[TB] FAIL reset_hist got=%0b/%0d want=0/0", hist_valid, hist_data); end
  endtask

  task automatic test_pin_verify();
    do_req(2'b00, 16'h1234, 16'd0, lat, bcnt);
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL pin_latency got=%0d want=4", lat); end
    total++; if (bcnt !== 5) begin bad++; $display("[TB] FAIL pin_busy_cycles got=%0d want=5", bcnt); end
    total++; if (pin_check !== 1'b1) begin bad++; $display("[TB] FAIL pin_good got=%0b want=1", pin_check); end
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("[TB] FAIL pin_after got=%0b/%0b want=0/0", resp_valid, busy); end
  endtask

  task automatic test_withdraw();
    logic [15:0] amts [5] = '{16'd300, 16'd800, 16'd0, 16'd700, 16'd1};
    logic        oks  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] bals [5] = '{16'd700, 16'd700, 16'd700, 16'd0, 16'd0};
    for (int k = 0; k < 5; k++) begin
      do_req(2'b01, 16'h0, amts[k], lat, bcnt);
      total++; if (transaction_success !== oks[k])
        begin bad++; $display("[TB] FAIL wd_success amt=%0d got=%0b want=%0b", amts[k], transaction_success, oks[k]); end
      total++; if (pin_check !== 1'b0) begin bad++; $display("[TB] FAIL wd_pin_cleared got=%0b want=0", pin_check); end
      @(posedge clk); #1;
      total++; if (balance !== bals[k])
        begin bad++; $display("[TB] FAIL wd_balance amt=%0d got=%0d want=%0d", amts[k], balance, bals[k]); end
    end
  endtask

  task automatic test_history();
    logic [15:0] exp_h [4] = '{16'd50, 16'd40, 16'd30, 16'd20};
    do_reset();
    do_req(2'b00, 16'h1234, 16'd0, lat, bcnt);
    for (int k = 1; k <= 5; k++) begin
      do_req(2'b01, 16'h0, 16'(10 * k), lat, bcnt);
      total++; if (transaction_success !== 1'b1) begin bad++; $display("[TB] FAIL hist_wd%0d got=%0b want=1", k, transaction_success); end
    end
    do_req(2'b10, 16'h0, 16'd0, lat, bcnt);
    total++; if (balance_enquiry_success !== 1'b1 || transaction_success !== 1'b0)
      begin bad++; $display("[TB] FAIL enquiry got=%0b/%0b want=1/0", balance_enquiry_success, transaction_success); end
    total++; if (balance !== 16'd850) begin bad++; $display("[TB] FAIL enquiry_balance got=%0d want=850", balance); end
    do_req(2'b11, 16'h0, 16'd0, lat, bcnt);
    total++; if (balance_enquiry_success !== 1'b1) begin bad++; $display("[TB] FAIL stmt_success got=%0b want=1", balance_enquiry_success); end
    collect_stream();
    total++; if (hq.size() !== 4) begin bad++; $display("[TB] FAIL stmt_count got=%0d want=4", hq.size()); end
    for (int i = 0; i < 4 && i < hq.size(); i++) begin
      total++; if (hq[i] !== exp_h[i]) begin bad++; $display("[TB] FAIL stmt_entry%0d got=%0d want=%0d", i, hq[i], exp_h[i]); end
    end
    total++; if (hlast - hfirst !== 3) begin bad++; $display("[TB] FAIL stmt_contiguous got=%0d want=3", hlast - hfirst); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL stmt_idle got=%0b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    req_valid = 1'b1; req_op = 2'b10;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    rcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (resp_valid) rcnt++;
      @(posedge clk); #1;
    end
    total++; if (rcnt !== 1) begin bad++; $display("[TB] FAIL ignored_req resp_count got=%0d want=1", rcnt); end
    req_valid = 1'b1; req_op = 2'b01; amount_in = 16'd100;
    @(posedge clk); #1 req_valid = 1'b0; session_end = 1'b1;
    @(posedge clk); #1 session_end = 1'b0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) begin lat = i; break; end
      @(posedge clk); #1;
    end
    total++; if (lat < 0) begin bad++; $display("[TB] FAIL sess_end_resp got=timeout want=resp"); end
    total++; if (transaction_success !== 1'b0) begin bad++; $display("[TB] FAIL sess_end_wd got=%0b want=0", transaction_success); end
    @(posedge clk); #1;
    total++; if (balance !== 16'd850) begin bad++; $display("[TB] FAIL sess_end_balance got=%0d want=850", balance); end
    do_req(2'b10, 16'h0, 16'd0, lat, bcnt);
    total++; if (balance_enquiry_success !== 1'b0) begin bad++; $display("[TB] FAIL sess_end_enquiry got=%0b want=0", balance_enquiry_success); end
  endtask

  task automatic test_reset_midop();
    do_req(2'b00, 16'h1234, 16'd0, lat, bcnt);
    wait_idle();
    req_valid = 1'b1; req_op = 2'b01; amount_in = 16'd100;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midop_busy got=%0b want=0", busy); end
    total++; if (balance !== 16'd1000) begin bad++; $display("[TB] FAIL midop_balance got=%0d want=1000", balance); end
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) rcnt++;
      @(posedge clk); #1;
    end
    total++; if (rcnt !== 0) begin bad++; $display("[TB] FAIL midop_no_resp got=%0d want=0", rcnt); end
    do_req(2'b11, 16'h0, 16'd0, lat, bcnt);
    total++; if (balance_enquiry_success !== 1'b0) begin bad++; $display("[TB] FAIL nopin_stmt got=%0b want=0", balance_enquiry_success); end
    collect_stream();
    total++; if (hq.size() !== 0) begin bad++; $display("[TB] FAIL nopin_stream got=%0d want=0", hq.size()); end
    do_req(2'b00, 16'h1234, 16'd0, lat, bcnt);
    do_req(2'b11, 16'h0, 16'd0, lat, bcnt);
    total++; if (balance_enquiry_success !== 1'b1) begin bad++; $display("[TB] FAIL empty_stmt got=%0b want=1", balance_enquiry_success); end
    collect_stream();
    total++; if (hq.size() !== 0 || busy !== 1'b0)
      begin bad++; $display("[TB] FAIL empty_stream got=%0d/%0b want=0/0", hq.size(), busy); end
  endtask

  task automatic test_lockout();
    logic exp_lock [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    do_req(2'b00, 16'h1234, 16'd0, lat, bcnt);
    for (int k = 0; k < 3; k++) begin
      do_req(2'b00, 16'h0000, 16'd0, lat, bcnt);
      total++; if (pin_check !== 1'b0) begin bad++; $display("[TB] FAIL bad_pin%0d got=%0b want=0", k, pin_check); end
      total++; if (locked !== exp_lock[k]) begin bad++; $display("[TB] FAIL lock_after%0d got=%0b want=%0b", k, locked, exp_lock[k]); end
    end
    do_req(2'b00, 16'h1234, 16'd0, lat, bcnt);
    total++; if (pin_check !== 1'b0 || locked !== 1'b1)
      begin bad++; $display("[TB] FAIL locked_good_pin got=%0b/%0b want=0/1", pin_check, locked); end
    do_req(2'b01, 16'h0, 16'd10, lat, bcnt);
    total++; if (transaction_success !== 1'b1) begin bad++; $display("[TB] FAIL locked_open_session got=%0b want=1", transaction_success); end
    @(posedge clk); #1;
    total++; if (balance !== 16'd990) begin bad++; $display("[TB] FAIL locked_balance got=%0d want=990", balance); end
  endtask

  initial begin
    test_reset();
    test_pin_verify();
    test_withdraw();
    test_history();
    test_back_to_back();
    test_reset_midop();
    test_lockout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
